// File: rtl/shift_out_stage.sv
// Output register stage for the barrel shifter: a 2-entry skid buffer that
// decouples out_ready from in_ready and counts delivered results.
//
// state | meaning
// EMPTY | no result held, Out_* keep their last values
// ONE   | head holds a result, skid free
// FULL  | head and skid both hold results, upstream stalled
module shift_out_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] In_result,
  input  logic [1:0]  In_op,
  input  logic [3:0]  In_cnt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Out_result,
  output logic [1:0]  Out_op,
  output logic [3:0]  Out_cnt,
  output logic        Out_zero,
  output logic        Out_msb,
  output logic [15:0] xfer_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic        accept;
  logic        emit;
  logic        load_head_in;
  logic        load_head_skid;
  logic        load_skid_in;

  logic [15:0] head_result, skid_result;
  logic [1:0]  head_op, skid_op;
  logic [3:0]  head_cnt, skid_cnt;
  logic        head_zero, skid_zero;
  logic        in_zero;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (accept) state_nxt = ONE;
      end
      ONE: begin
        if (accept && !emit)      state_nxt = FULL;
        else if (!accept && emit) state_nxt = EMPTY;
        else                      state_nxt = ONE;
      end
      FULL: begin
        if (emit) state_nxt = ONE;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Output / control decode; in_ready depends only on state and reset
  always_comb begin
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid_in   = 1'b0;
    accept         = 1'b0;
    emit           = 1'b0;
    in_ready  = !rst && (state != FULL);
    out_valid = (state == ONE) || (state == FULL);
    accept    = in_valid && in_ready;
    emit      = out_valid && out_ready;
    case (state)
      EMPTY: begin
        load_head_in = accept;
      end
      ONE: begin
        load_head_in = accept && emit;
        load_skid_in = accept && !emit;
      end
      FULL: begin
        load_head_skid = emit;
      end
      default: begin
        load_head_in = 1'b0;
      end
    endcase
  end

  assign in_zero = (In_result == 16'h0000);

  // Datapath registers; zero flag is captured with the data so no output
  // sees a combinational path from In_result.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_result <= 16'h0000;
      head_op     <= 2'b00;
      head_cnt    <= 4'h0;
      head_zero   <= 1'b0;
      skid_result <= 16'h0000;
      skid_op     <= 2'b00;
      skid_cnt    <= 4'h0;
      skid_zero   <= 1'b0;
      xfer_cnt    <= 16'h0000;
    end else begin
      if (load_head_in) begin
        head_result <= In_result;
        head_op     <= In_op;
        head_cnt    <= In_cnt;
        head_zero   <= in_zero;
      end else if (load_head_skid) begin
        head_result <= skid_result;
        head_op     <= skid_op;
        head_cnt    <= skid_cnt;
        head_zero   <= skid_zero;
      end
      if (load_skid_in) begin
        skid_result <= In_result;
        skid_op     <= In_op;
        skid_cnt    <= In_cnt;
        skid_zero   <= in_zero;
      end
      if (emit) begin
        xfer_cnt <= xfer_cnt + 16'd1;
      end
    end
  end

  assign Out_result = head_result;
  assign Out_op     = head_op;
  assign Out_cnt    = head_cnt;
  assign Out_zero   = head_zero;
  assign Out_msb    = head_result[15];

endmodule

// File: tb/tb_shift_out_stage.sv
// Bench for shift_out_stage: directed scenarios plus randomized traffic,
// checked by a FIFO-occupancy reference model in a negedge monitor.
module tb_shift_out_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] In_result;
  logic [1:0]  In_op;
  logic [3:0]  In_cnt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Out_result;
  logic [1:0]  Out_op;
  logic [3:0]  Out_cnt;
  logic        Out_zero;
  logic        Out_msb;
  logic [15:0] xfer_cnt;

  shift_out_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .In_result  (In_result),
    .In_op      (In_op),
    .In_cnt     (In_cnt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Out_result (Out_result),
    .Out_op     (Out_op),
    .Out_cnt    (Out_cnt),
    .Out_zero   (Out_zero),
    .Out_msb    (Out_msb),
    .xfer_cnt   (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] r;
    logic [1:0]  op;
    logic [3:0]  cnt;
    logic        z;
  } item_t;

  int tests = 0;
  int fails = 0;

  // Reference model: a 2-deep FIFO of accepted items plus the last value shown.
  item_t       q[$];
  item_t       last_out;
  item_t       cur;
  logic [15:0] exp_xfer;
  logic        m_accept;
  logic        m_emit;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready_in_rst", {31'd0, in_ready}, 32'd0);
      q.delete();
      last_out = '0;
      exp_xfer = 16'h0000;
    end else begin
      cur = (q.size() > 0) ? q[0] : last_out;
      chk("in_ready",   {31'd0, in_ready},  {31'd0, (q.size() < 2)});
      chk("out_valid",  {31'd0, out_valid}, {31'd0, (q.size() > 0)});
      chk("out_result", {16'd0, Out_result}, {16'd0, cur.r});
      chk("out_op",     {30'd0, Out_op},     {30'd0, cur.op});
      chk("out_cnt",    {28'd0, Out_cnt},    {28'd0, cur.cnt});
      chk("out_zero",   {31'd0, Out_zero},   {31'd0, cur.z});
      chk("out_msb",    {31'd0, Out_msb},    {31'd0, cur.r[15]});
      chk("xfer_cnt",   {16'd0, xfer_cnt},   {16'd0, exp_xfer});
      m_accept = in_valid && (q.size() < 2);
      m_emit   = out_ready && (q.size() > 0);
      if (m_emit) begin
        last_out = q.pop_front();
        exp_xfer = exp_xfer + 16'd1;
      end
      if (m_accept) q.push_back({In_result, In_op, In_cnt, (In_result == 16'h0000)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends n items with given valid/ready percentages, then drains the stage.
  task automatic run(input int n, input int pv, input int pr, input bit seq, input int base);
    int sent = 0;
    int budget = n * 50 + 100;
    logic [15:0] r;
    logic [1:0]  o;
    logic [3:0]  c;
    r = seq ? 16'(base) : 16'($urandom);
    o = 2'($urandom);
    c = 4'($urandom);
    while (sent < n && budget > 0) begin
      in_valid  = ($urandom_range(99) < pv);
      In_result = r;
      In_op     = o;
      In_cnt    = c;
      out_ready = ($urandom_range(99) < pr);
      @(negedge clk);
      if (in_valid && in_ready) begin
        sent++;
        r = seq ? 16'(base + sent) : 16'($urandom);
        o = 2'($urandom);
        c = 4'($urandom);
      end
      step();
      budget--;
    end
    if (sent < n) chk("run_send_timeout", sent, n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget = 10;
    while (out_valid && budget > 0) begin
      step();
      budget--;
    end
    chk("run_drain", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    In_result = 16'h0000;
    In_op     = 2'b00;
    In_cnt    = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_result", {16'd0, Out_result}, 32'd0);
    chk("reset_in_ready",   {31'd0, in_ready},   32'd1);
    chk("reset_xfer",       {16'd0, xfer_cnt},   32'd0);
    step();

    // Single result with immediate downstream acceptance
    out_ready = 1'b1;
    in_valid  = 1'b1;
    In_result = 16'h8001;
    In_op     = 2'b01;
    In_cnt    = 4'h8;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("s1_valid",  {31'd0, out_valid},  32'd1);
    chk("s1_result", {16'd0, Out_result}, 32'h8001);
    chk("s1_msb",    {31'd0, Out_msb},    32'd1);
    chk("s1_zero",   {31'd0, Out_zero},   32'd0);
    chk("s1_cnt",    {28'd0, Out_cnt},    32'd8);
    step();
    @(negedge clk);
    chk("s1_xfer", {16'd0, xfer_cnt}, 32'd1);
    step();

    // Fill to FULL with downstream stalled, then release
    out_ready = 1'b0;
    in_valid  = 1'b1;
    In_result = 16'h0000;
    In_op     = 2'b10;
    In_cnt    = 4'h3;
    step();
    In_result = 16'h1234;
    In_op     = 2'b11;
    In_cnt    = 4'hC;
    step();
    in_valid  = 1'b0;
    In_result = 16'hFFFF;
    @(negedge clk);
    chk("s2_zero",     {31'd0, Out_zero},   32'd1);
    chk("s2_full_rdy", {31'd0, in_ready},   32'd0);
    chk("s2_head",     {16'd0, Out_result}, 32'h0000);
    step();
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("s2_second",  {16'd0, Out_result}, 32'h1234);
    chk("s2_rdy_back", {31'd0, in_ready},  32'd1);
    step();
    @(negedge clk);
    chk("s2_empty", {31'd0, out_valid}, 32'd0);
    chk("s2_xfer",  {16'd0, xfer_cnt},  32'd3);
    step();

    // Back-to-back stream 1..100
    run(100, 100, 100, 1'b1, 1);
    @(negedge clk);
    chk("s3_xfer", {16'd0, xfer_cnt}, 32'd103);
    step();

    // Reset while FULL discards both buffered items
    out_ready = 1'b0;
    in_valid  = 1'b1;
    In_result = 16'hAAAA;
    step();
    In_result = 16'h5555;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("s5_full", {31'd0, in_ready}, 32'd0);
    step();
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("s5_valid",  {31'd0, out_valid},  32'd0);
    chk("s5_xfer",   {16'd0, xfer_cnt},   32'd0);
    chk("s5_result", {16'd0, Out_result}, 32'd0);
    repeat (4) step();

    // Random traffic, 10k items
    run(10000, 75, 75, 1'b0, 0);
    @(negedge clk);
    chk("s4_xfer", {16'd0, xfer_cnt}, 32'd10000);
    step();

    // Bring the counter to FFFF, then wrap it
    run(55535, 100, 100, 1'b0, 0);
    @(negedge clk);
    chk("s6_ffff", {16'd0, xfer_cnt}, 32'hFFFF);
    step();
    run(1, 100, 100, 1'b0, 0);
    @(negedge clk);
    chk("s6_wrap", {16'd0, xfer_cnt}, 32'h0000);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
